// File: rtl/tx_cpl_tag_to_bram_pkg.sv
// Shared constants, TRN header field positions and small helpers for the
// completion-to-BRAM path.
package tx_cpl_tag_to_bram_pkg;

    localparam logic [6:0] CPLD_FMT_TYPE = 7'b10_01010;
    localparam logic [2:0] CPL_STATUS_SC = 3'b000;

    // Field positions within a 64-bit TRN beat
    localparam int FMT_TYPE_LSB = 56;
    localparam int LEN_LSB      = 32;
    localparam int STATUS_LSB   = 13;
    localparam int TAG_LSB      = 40;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR2,
        S_DATA,
        S_DROP
    } cpl_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] c, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/tx_cpl_tag_to_bram_tag_table.sv
// Outstanding read-tag storage: in-order allocation, per-tag qword
// accounting and in-order retirement.
module tx_tag_table
    import tx_cpl_tag_to_bram_pkg::*;
#(
    parameter int AW   = 10,
    parameter int TAGS = 4,
    parameter int TW   = $clog2(TAGS)
) (
    input  logic          trn_clk,
    input  logic          reset_n,
    input  logic          i_alloc,
    input  logic [AW-1:0] i_alloc_base,
    input  logic [8:0]    i_alloc_qwords,
    output logic          o_req_ready,
    output logic [TW-1:0] o_alloc_ptr,
    input  logic [TW-1:0] i_look_tag,
    output logic          o_look_valid,
    output logic [AW-1:0] o_look_base,
    output logic [8:0]    o_look_expected,
    output logic [8:0]    o_look_received,
    input  logic          i_inc,
    input  logic [TW-1:0] i_inc_tag,
    output logic          o_retire,
    output logic [AW-1:0] o_retire_addr,
    output logic          o_all_done
);

    logic [TAGS-1:0] r_valid;
    logic [AW-1:0]   r_base     [TAGS];
    logic [8:0]      r_expected [TAGS];
    logic [8:0]      r_received [TAGS];
    logic [TW-1:0]   r_alloc_ptr;
    logic [TW-1:0]   r_retire_ptr;

    assign o_req_ready     = !r_valid[r_alloc_ptr];
    assign o_alloc_ptr     = r_alloc_ptr;
    assign o_look_valid    = r_valid[i_look_tag];
    assign o_look_base     = r_base[i_look_tag];
    assign o_look_expected = r_expected[i_look_tag];
    assign o_look_received = r_received[i_look_tag];
    assign o_retire        = r_valid[r_retire_ptr] &&
                             (r_received[r_retire_ptr] == r_expected[r_retire_ptr]);
    assign o_retire_addr   = r_base[r_retire_ptr] + AW'(r_expected[r_retire_ptr]);
    assign o_all_done      = ~|r_valid;

    // An allocating entry is never valid, so it can never be the one retiring.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= '0;
            r_alloc_ptr  <= '0;
            r_retire_ptr <= '0;
            for (int i = 0; i < TAGS; i++) begin
                r_base[i]     <= '0;
                r_expected[i] <= '0;
                r_received[i] <= '0;
            end
        end else begin
            if (i_inc) begin
                r_received[i_inc_tag] <= r_received[i_inc_tag] + 9'd1;
            end
            if (o_retire) begin
                r_valid[r_retire_ptr] <= 1'b0;
                r_retire_ptr          <= r_retire_ptr + TW'(1);
            end
            if (i_alloc) begin
                r_valid[r_alloc_ptr]    <= 1'b1;
                r_base[r_alloc_ptr]     <= i_alloc_base;
                r_expected[r_alloc_ptr] <= i_alloc_qwords;
                r_received[r_alloc_ptr] <= '0;
                r_alloc_ptr             <= r_alloc_ptr + TW'(1);
            end
        end
    end

endmodule

// File: rtl/tx_cpl_tag_to_bram.sv
// Steers TRN CplD payload into BRAM at the address reserved by its read tag
// and reports the committed write pointer as tags retire in order.
//
// state  | meaning
// S_IDLE | waiting for a SOF beat
// S_HDR2 | second header beat: tag lookup, first data DW captured
// S_DATA | payload beats written to BRAM
// S_DROP | discarding the rest of a rejected TLP
module tx_cpl_tag_to_bram
    import tx_cpl_tag_to_bram_pkg::*;
#(
    parameter int AW     = 10,
    parameter int TAGS   = 4,
    parameter int MAX_QW = 64
) (
    input  logic          trn_clk,
    input  logic          reset_n,
    input  logic [63:0]   trn_rd,
    input  logic [7:0]    trn_rrem_n,
    input  logic          trn_rsof_n,
    input  logic          trn_reof_n,
    input  logic          trn_rsrc_rdy_n,
    input  logic          trn_rdst_rdy_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_base,
    input  logic [8:0]    req_qwords,
    output logic [4:0]    req_tag,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic          wr_en,
    output logic [AW-1:0] commited_wr_addr,
    output logic          wr_addr_updated,
    output logic          all_done,
    output logic [15:0]   err_tag_cnt,
    output logic [15:0]   err_status_cnt,
    output logic [15:0]   err_len_cnt
);

    localparam int TW = $clog2(TAGS);

    cpl_state_t    r_state, w_state_nxt;
    logic [9:0]    r_len;
    logic [2:0]    r_status;
    logic [TW-1:0] r_tag;
    logic [31:0]   r_aux;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [63:0]   r_wr_data;
    logic [AW-1:0] r_cmt;
    logic [7:0]    r_upd_cnt;
    logic [15:0]   r_err_tag, r_err_stat, r_err_len;

    logic          w_beat, w_req_ready, w_req_len_ok, w_alloc, w_err_len_req;
    logic [TW-1:0] w_alloc_ptr, w_look_tag;
    logic          w_look_valid, w_retire;
    logic [AW-1:0] w_look_base, w_retire_addr;
    logic [8:0]    w_look_expected, w_look_received;
    logic [7:0]    w_hdr_tag;
    logic          w_tag_ok, w_stat_ok, w_len_ok, w_hdr_ok;
    logic          w_cap_hdr, w_cap_tag, w_wr_fire, w_err_tag, w_err_stat, w_err_len_hdr;
    logic [7:0]    w_upd_dec;
    logic [8:0]    w_upd_sum;
    logic          w_unused_rrem;

    assign w_unused_rrem = ^trn_rrem_n;
    assign w_beat        = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;

    assign w_req_len_ok  = (req_qwords != 9'd0) && (req_qwords <= 9'(MAX_QW));
    assign w_alloc       = req_valid && w_req_ready && w_req_len_ok;
    assign w_err_len_req = req_valid && w_req_ready && !w_req_len_ok;

    assign w_hdr_tag  = trn_rd[TAG_LSB +: 8];
    assign w_look_tag = (r_state == S_HDR2) ? trn_rd[TAG_LSB +: TW] : r_tag;

    tx_tag_table #(.AW(AW), .TAGS(TAGS), .TW(TW)) u_tag_table (
        .trn_clk        (trn_clk),
        .reset_n        (reset_n),
        .i_alloc        (w_alloc),
        .i_alloc_base   (req_base),
        .i_alloc_qwords (req_qwords),
        .o_req_ready    (w_req_ready),
        .o_alloc_ptr    (w_alloc_ptr),
        .i_look_tag     (w_look_tag),
        .o_look_valid   (w_look_valid),
        .o_look_base    (w_look_base),
        .o_look_expected(w_look_expected),
        .o_look_received(w_look_received),
        .i_inc          (w_wr_fire),
        .i_inc_tag      (r_tag),
        .o_retire       (w_retire),
        .o_retire_addr  (w_retire_addr),
        .o_all_done     (all_done)
    );

    // The completion must fit in what is still outstanding for its tag.
    assign w_tag_ok  = (w_hdr_tag < 8'(TAGS)) && w_look_valid;
    assign w_stat_ok = (r_status == CPL_STATUS_SC);
    assign w_len_ok  = (r_len != 10'd0) && !r_len[0] &&
                       (({2'b0, w_look_received} + {2'b0, r_len[9:1]}) <= {2'b0, w_look_expected});
    assign w_hdr_ok  = w_tag_ok && w_stat_ok && w_len_ok;

    always_comb begin
        w_state_nxt   = r_state;
        w_cap_hdr     = 1'b0;
        w_cap_tag     = 1'b0;
        w_wr_fire     = 1'b0;
        w_err_tag     = 1'b0;
        w_err_stat    = 1'b0;
        w_err_len_hdr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_beat && !trn_rsof_n) begin
                    if (trn_rd[FMT_TYPE_LSB +: 7] == CPLD_FMT_TYPE) begin
                        w_cap_hdr   = 1'b1;
                        w_state_nxt = trn_reof_n ? S_HDR2 : S_IDLE;
                    end else if (trn_reof_n) begin
                        w_state_nxt = S_DROP;
                    end
                end
            end
            S_HDR2: begin
                if (w_beat) begin
                    if (w_hdr_ok) begin
                        w_cap_tag   = 1'b1;
                        w_state_nxt = trn_reof_n ? S_DATA : S_IDLE;
                    end else begin
                        if (!w_tag_ok)       w_err_tag     = 1'b1;
                        else if (!w_stat_ok) w_err_stat    = 1'b1;
                        else                 w_err_len_hdr = 1'b1;
                        w_state_nxt = trn_reof_n ? S_DROP : S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_beat) begin
                    w_wr_fire = 1'b1;
                    if (!trn_reof_n) w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (w_beat && !trn_reof_n) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Back-to-back retirements stack 3 more cycles onto the running pulse.
    assign w_upd_dec = (r_upd_cnt == 8'd0) ? 8'd0 : r_upd_cnt - 8'd1;
    assign w_upd_sum = {1'b0, w_upd_dec} + 9'd3;

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_status   <= '0;
            r_tag      <= '0;
            r_aux      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cmt      <= '0;
            r_upd_cnt  <= '0;
            r_err_tag  <= '0;
            r_err_stat <= '0;
            r_err_len  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap_hdr) begin
                r_len    <= trn_rd[LEN_LSB +: 10];
                r_status <= trn_rd[STATUS_LSB +: 3];
            end
            if (w_cap_tag) begin
                r_tag <= trn_rd[TAG_LSB +: TW];
                r_aux <= trn_rd[31:0];
            end
            r_wr_en <= w_wr_fire;
            if (w_wr_fire) begin
                r_wr_addr <= w_look_base + AW'(w_look_received);
                r_wr_data <= {bswap32(trn_rd[63:32]), bswap32(r_aux)};
                r_aux     <= trn_rd[31:0];
            end
            if (w_retire) begin
                r_cmt     <= w_retire_addr;
                r_upd_cnt <= w_upd_sum[8] ? 8'hFF : w_upd_sum[7:0];
            end else begin
                r_upd_cnt <= w_upd_dec;
            end
            r_err_tag  <= sat_add16(r_err_tag, {1'b0, w_err_tag});
            r_err_stat <= sat_add16(r_err_stat, {1'b0, w_err_stat});
            r_err_len  <= sat_add16(r_err_len, 2'(w_err_len_hdr) + 2'(w_err_len_req));
        end
    end

    assign req_ready        = w_req_ready;
    assign req_tag          = 5'(w_alloc_ptr);
    assign wr_en            = r_wr_en;
    assign wr_addr          = r_wr_addr;
    assign wr_data          = r_wr_data;
    assign commited_wr_addr = r_cmt;
    assign wr_addr_updated  = (r_upd_cnt != 8'd0);
    assign err_tag_cnt      = r_err_tag;
    assign err_status_cnt   = r_err_stat;
    assign err_len_cnt      = r_err_len;

endmodule

// File: tb/tb_tx_cpl_tag_to_bram.sv
// Directed bench for tx_cpl_tag_to_bram: expected BRAM writes are queued as
// completions are driven and compared as the DUT writes them.
module tb_tx_cpl_tag_to_bram;

    localparam int AW = 10;

    logic          trn_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [63:0]   trn_rd = '0;
    logic [7:0]    trn_rrem_n = '0;
    logic          trn_rsof_n = 1'b1, trn_reof_n = 1'b1;
    logic          trn_rsrc_rdy_n = 1'b1, trn_rdst_rdy_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_base = '0;
    logic [8:0]    req_qwords = '0;
    logic          req_ready, wr_en, wr_addr_updated, all_done;
    logic [4:0]    req_tag;
    logic [AW-1:0] wr_addr, commited_wr_addr;
    logic [63:0]   wr_data;
    logic [15:0]   err_tag_cnt, err_status_cnt, err_len_cnt;

    tx_cpl_tag_to_bram #(.AW(AW), .TAGS(4), .MAX_QW(64)) dut (
        .trn_clk(trn_clk), .reset_n(reset_n),
        .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
        .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
        .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
        .req_qwords(req_qwords), .req_tag(req_tag),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .commited_wr_addr(commited_wr_addr), .wr_addr_updated(wr_addr_updated),
        .all_done(all_done),
        .err_tag_cnt(err_tag_cnt), .err_status_cnt(err_status_cnt), .err_len_cnt(err_len_cnt)
    );

    always #5 trn_clk = ~trn_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    wr_t           wq[$];
    logic [AW-1:0] cq[$];
    int            cyq[$];
    int            n_vec = 0, n_fail = 0;
    int            cyc = 0, run = 0, last_pulse = 0;
    logic [AW-1:0] prev_cmt = '0;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard, retirement log and pulse-length measurement
    always @(negedge trn_clk) begin
        cyc++;
        if (!reset_n) begin
            run      = 0;
            prev_cmt = '0;
        end else begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    check("unexpected_wr", 64'(wr_en), 64'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", wr_data, e.data);
                end
            end
            if (commited_wr_addr != prev_cmt) begin
                cq.push_back(commited_wr_addr);
                cyq.push_back(cyc);
                prev_cmt = commited_wr_addr;
            end
            if (wr_addr_updated) begin
                run++;
            end else if (run != 0) begin
                last_pulse = run;
                run = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge trn_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        trn_rsrc_rdy_n = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge trn_clk);
        #1;
        reset_n = 1'b1;
        wq.delete();
        cq.delete();
        cyq.delete();
        last_pulse = 0;
    endtask

    task automatic beat(input logic [63:0] d, input logic sof, input logic eof);
        trn_rd = d;
        trn_rsof_n = !sof;
        trn_reof_n = !eof;
        trn_rsrc_rdy_n = 1'b0;
        @(posedge trn_clk);
        #1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n = 1'b1;
        trn_reof_n = 1'b1;
    endtask

    task automatic request(input logic [AW-1:0] base, input logic [8:0] q,
                           input logic exp_ready, input logic [4:0] exp_tag);
        req_valid = 1'b1;
        req_base = base;
        req_qwords = q;
        @(negedge trn_clk);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("req_tag", 64'(req_tag), 64'(exp_tag));
        @(posedge trn_clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send_cpld(input logic [7:0] tag, input logic [9:0] len, input logic [2:0] st,
                             input bit ok, input logic [AW-1:0] addr0);
        logic [63:0] h;
        logic [31:0] prev, a, b;
        int          nb;
        h = '0;
        h[62:56] = 7'b10_01010;
        h[41:32] = len;
        h[15:13] = st;
        beat(h, 1'b1, 1'b0);
        prev = $urandom;
        h = '0;
        h[47:40] = tag;
        h[31:0] = prev;
        beat(h, 1'b0, 1'b0);
        nb = int'(len) / 2;
        if (nb == 0) nb = 1;
        for (int k = 0; k < nb; k++) begin
            a = $urandom;
            b = $urandom;
            if (ok) wq.push_back('{addr: addr0 + AW'(k), data: {bswap(a), bswap(prev)}});
            prev = b;
            beat({a, b}, 1'b0, k == nb - 1);
        end
    endtask

    task automatic wait_cmt(input logic [AW-1:0] exp, input string tag);
        int n;
        n = 0;
        while (commited_wr_addr !== exp && n < 2000) begin
            @(negedge trn_clk);
            n++;
        end
        check(tag, 64'(commited_wr_addr), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] h;
        logic [31:0] prev, a, b;

        // Reset state
        repeat (3) @(posedge trn_clk);
        @(negedge trn_clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_all_done", 64'(all_done), 64'd1);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_cmt", 64'(commited_wr_addr), 64'd0);
        check("rst_upd", 64'(wr_addr_updated), 64'd0);
        check("rst_req_tag", 64'(req_tag), 64'd0);
        check("rst_errs", {16'd0, err_tag_cnt, err_status_cnt, err_len_cnt}, 64'd0);
        do_reset();

        // Single request, single CplD
        request(10'h010, 9'd4, 1'b1, 5'd0);
        check("a_busy", 64'(all_done), 64'd0);
        send_cpld(8'd0, 10'd8, 3'b000, 1'b1, 10'h010);
        wait_cmt(10'h014, "a_cmt");
        idle(8);
        check("a_pulse", 64'(last_pulse), 64'd3);
        check("a_ncmt", 64'(cq.size()), 64'd1);
        check("a_wq", 64'(wq.size()), 64'd0);
        check("a_done", 64'(all_done), 64'd1);

        // Out-of-order completions, in-order retirement
        do_reset();
        request(10'h000, 9'd64, 1'b1, 5'd0);
        request(10'h040, 9'd64, 1'b1, 5'd1);
        send_cpld(8'd1, 10'd64, 3'b000, 1'b1, 10'h040);
        send_cpld(8'd1, 10'd64, 3'b000, 1'b1, 10'h060);
        idle(4);
        check("b_cmt_hold", 64'(commited_wr_addr), 64'd0);
        check("b_ncmt_hold", 64'(cq.size()), 64'd0);
        send_cpld(8'd0, 10'd128, 3'b000, 1'b1, 10'h000);
        wait_cmt(10'h080, "b_cmt_final");
        idle(10);
        check("b_ncmt", 64'(cq.size()), 64'd2);
        check("b_cmt0", 64'(cq[0]), 64'h040);
        check("b_cmt1", 64'(cq[1]), 64'h080);
        check("b_consec", 64'(cyq[1] - cyq[0]), 64'd1);
        check("b_pulse", 64'(last_pulse), 64'd6);
        check("b_wq", 64'(wq.size()), 64'd0);

        // Split completions accumulate on one tag
        do_reset();
        request(10'h100, 9'd64, 1'b1, 5'd0);
        for (int s = 0; s < 3; s++) send_cpld(8'd0, 10'd32, 3'b000, 1'b1, 10'h100 + AW'(16 * s));
        idle(3);
        check("c_ncmt_hold", 64'(cq.size()), 64'd0);
        send_cpld(8'd0, 10'd32, 3'b000, 1'b1, 10'h130);
        wait_cmt(10'h140, "c_cmt");
        idle(6);
        check("c_ncmt", 64'(cq.size()), 64'd1);
        check("c_wq", 64'(wq.size()), 64'd0);

        // Rejected completions and requests
        do_reset();
        request(10'h020, 9'd4, 1'b1, 5'd0);
        send_cpld(8'd0, 10'd8, 3'b001, 1'b0, 10'h000);
        check("d_err_stat", 64'(err_status_cnt), 64'd1);
        check("d_err_tag0", 64'(err_tag_cnt), 64'd0);
        send_cpld(8'd7, 10'd8, 3'b000, 1'b0, 10'h000);
        check("d_err_tag1", 64'(err_tag_cnt), 64'd1);
        send_cpld(8'd1, 10'd8, 3'b000, 1'b0, 10'h000);
        check("d_err_tag2", 64'(err_tag_cnt), 64'd2);
        send_cpld(8'd0, 10'd10, 3'b000, 1'b0, 10'h000);
        check("d_err_len1", 64'(err_len_cnt), 64'd1);
        request(10'h000, 9'd0, 1'b1, 5'd1);
        check("d_err_len2", 64'(err_len_cnt), 64'd2);
        request(10'h000, 9'd65, 1'b1, 5'd1);
        check("d_err_len3", 64'(err_len_cnt), 64'd3);
        @(negedge trn_clk);
        check("d_tag_kept", 64'(req_tag), 64'd1);
        @(posedge trn_clk);
        #1;
        send_cpld(8'd0, 10'd8, 3'b000, 1'b1, 10'h020);
        wait_cmt(10'h024, "d_cmt");
        idle(2);
        check("d_wq", 64'(wq.size()), 64'd0);
        check("d_err_stat_end", 64'(err_status_cnt), 64'd1);

        // Table full, then one retirement frees tag 0
        do_reset();
        for (int i = 0; i < 4; i++) request(10'h200 + AW'(16 * i), 9'd2, 1'b1, 5'(i));
        @(negedge trn_clk);
        check("e_full_ready", 64'(req_ready), 64'd0);
        @(posedge trn_clk);
        #1;
        send_cpld(8'd0, 10'd4, 3'b000, 1'b1, 10'h200);
        wait_cmt(10'h202, "e_cmt");
        check("e_ready", 64'(req_ready), 64'd1);
        check("e_tag", 64'(req_tag), 64'd0);
        check("e_busy", 64'(all_done), 64'd0);
        idle(2);

        // Reset in the middle of a payload
        do_reset();
        request(10'h300, 9'd4, 1'b1, 5'd0);
        h = '0;
        h[62:56] = 7'b10_01010;
        h[41:32] = 10'd8;
        beat(h, 1'b1, 1'b0);
        prev = $urandom;
        h = '0;
        h[31:0] = prev;
        beat(h, 1'b0, 1'b0);
        a = $urandom;
        b = $urandom;
        wq.push_back('{addr: 10'h300, data: {bswap(a), bswap(prev)}});
        beat({a, b}, 1'b0, 1'b0);
        trn_rd = {$urandom, $urandom};
        trn_rsrc_rdy_n = 1'b0;
        #6;
        reset_n = 1'b0;
        @(posedge trn_clk);
        @(posedge trn_clk);
        #1;
        reset_n = 1'b1;
        beat({$urandom, $urandom}, 1'b0, 1'b0);
        beat({$urandom, $urandom}, 1'b0, 1'b1);
        idle(5);
        @(negedge trn_clk);
        check("f_wq", 64'(wq.size()), 64'd0);
        check("f_done", 64'(all_done), 64'd1);
        check("f_ready", 64'(req_ready), 64'd1);
        check("f_wr_en", 64'(wr_en), 64'd0);
        check("f_tag", 64'(req_tag), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
